// File: rtl/data_mem_master_pkg.sv
// rtl/data_mem_master_pkg.sv - shared op encodings, RAM strobe levels and helpers
//
// Purpose: types and helpers shared by the data-RAM initiator.
// Contents: mem_op_e (MEM_NOP..MEM_SW), ChipEnable/ChipDisable and
// WriteEnable/WriteDisable strobe levels (also used by the RAM),
// state_e for the access FSM, and op classification helpers.
package data_mem_master_pkg;

   typedef enum logic [3:0] {
      MEM_NOP = 4'd0,
      MEM_LB  = 4'd1,
      MEM_LBU = 4'd2,
      MEM_LH  = 4'd3,
      MEM_LHU = 4'd4,
      MEM_LW  = 4'd5,
      MEM_SB  = 4'd6,
      MEM_SH  = 4'd7,
      MEM_SW  = 4'd8
   } mem_op_e;

   localparam logic ChipEnable   = 1'b1;
   localparam logic ChipDisable  = 1'b0;
   localparam logic WriteEnable  = 1'b1;
   localparam logic WriteDisable = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   function automatic logic is_store(input mem_op_e op);
      return op inside {MEM_SB, MEM_SH, MEM_SW};
   endfunction

   // Halfwords need an even address, words need a 4-byte aligned address.
   function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] offset);
      case (op)
         MEM_LH, MEM_LHU, MEM_SH: return offset[0];
         MEM_LW, MEM_SW:          return offset != 2'b00;
         default:                 return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/data_mem_master_if.sv
// rtl/data_mem_master_if.sv - data-RAM port bundle between initiator and RAM
//
// Purpose: groups the RAM-side signals of the data memory port.
// Signals: ce (chip enable), we (write enable), sel (byte lanes, sel[3] =
// bits 31:24), addr (word-aligned byte address), wdata (lane-replicated
// store data), rdata (RAM read word).
// Modports: master (initiator), slave (RAM).
interface data_mem_master_if #(
   parameter int ADDR_W = 32
);
   logic              ce;
   logic              we;
   logic [3:0]        sel;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;

   modport master (output ce, we, sel, addr, wdata, input rdata);
   modport slave  (input ce, we, sel, addr, wdata, output rdata);
endinterface

// File: rtl/data_mem_master_lane_align.sv
// rtl/data_mem_master_lane_align.sv - big-endian byte-lane steering for the data port
//
// Purpose: combinational lane logic for one memory op.
// Ports: op, offset (addr[1:0]), wdata (right-justified store data),
//        rword (RAM read word) in; sel (byte lanes), wdata_rep (replicated
//        store data), rdata_ext (extended load result) out.
// Offset 0 is the most significant lane (bits 31:24).
module mem_lane_align
   import data_mem_master_pkg::*;
(
   input  mem_op_e     op,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  sel,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v    = 8'h00;
      half_v    = 16'h0000;
      sel       = 4'b0000;
      wdata_rep = 32'h0;
      rdata_ext = 32'h0;

      case (offset)
         2'd0:    byte_v = rword[31:24];
         2'd1:    byte_v = rword[23:16];
         2'd2:    byte_v = rword[15:8];
         default: byte_v = rword[7:0];
      endcase
      half_v = offset[1] ? rword[15:0] : rword[31:16];

      case (op)
         MEM_LB, MEM_LBU, MEM_SB: sel = 4'b1000 >> offset;
         MEM_LH, MEM_LHU, MEM_SH: sel = offset[1] ? 4'b0011 : 4'b1100;
         MEM_LW, MEM_SW:          sel = 4'b1111;
         default:                 sel = 4'b0000;
      endcase

      case (op)
         MEM_SB:  wdata_rep = {4{wdata[7:0]}};
         MEM_SH:  wdata_rep = {2{wdata[15:0]}};
         MEM_SW:  wdata_rep = wdata;
         default: wdata_rep = 32'h0;
      endcase

      case (op)
         MEM_LB:  rdata_ext = {{24{byte_v[7]}}, byte_v};
         MEM_LBU: rdata_ext = {24'h0, byte_v};
         MEM_LH:  rdata_ext = {{16{half_v[15]}}, half_v};
         MEM_LHU: rdata_ext = {16'h0, half_v};
         MEM_LW:  rdata_ext = rword;
         default: rdata_ext = 32'h0;
      endcase
   end

endmodule

// File: rtl/data_mem_master.sv
// rtl/data_mem_master.sv - MEM-stage initiator for the data RAM
//
// Purpose: turns load/store micro-ops into fixed-latency RAM cycles, stalls
// the pipeline for the access, returns extended load data and reports
// misaligned accesses without touching the RAM.
// Ports: clk, rst (sync, active high);
//        pipeline side: req_i, op_i, addr_i, wdata_i, flush_i in;
//                       stall_o, done_o, err_o, badaddr_o, rdata_o out;
//        ram: data_mem_master_if.master (ce, we, sel, addr, wdata / rdata).
module data_mem_master
   import data_mem_master_pkg::*;
#(
   parameter int LATENCY = 1,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_i,
   input  logic [3:0]        op_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              flush_i,
   output logic              stall_o,
   output logic              done_o,
   output logic              err_o,
   output logic [ADDR_W-1:0] badaddr_o,
   output logic [DATA_W-1:0] rdata_o,
   data_mem_master_if.master ram
);

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   state_e            state;
   mem_op_e           op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic [3:0]        count;
   logic              ce_r;
   logic              we_r;
   logic              done_r;
   logic              err_r;

   mem_op_e           op_in;
   logic              accept;
   logic              mis_in;
   logic [3:0]        sel;
   logic [31:0]       wdata_rep;
   logic [31:0]       rdata_ext;

   assign op_in  = mem_op_e'(op_i);
   assign mis_in = is_misaligned(op_in, addr_i[1:0]);
   // Reset blocks acceptance so every output is quiet while rst is held.
   assign accept = !rst && (state == ST_IDLE) && req_i && (op_in != MEM_NOP) && !flush_i;

   mem_lane_align u_lane_align (
      .op        (op_q),
      .offset    (addr_q[1:0]),
      .wdata     (wdata_q),
      .rword     (ram.rdata),
      .sel       (sel),
      .wdata_rep (wdata_rep),
      .rdata_ext (rdata_ext)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         op_q    <= MEM_NOP;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         count   <= '0;
         ce_r    <= ChipDisable;
         we_r    <= WriteDisable;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q    <= op_in;
                  addr_q  <= addr_i;
                  wdata_q <= 32'(wdata_i);
                  count   <= LAT_M1;
                  rdata_q <= '0;
                  if (mis_in) begin
                     err_r  <= 1'b1;
                     done_r <= 1'b1;
                     state  <= ST_DONE;
                  end else begin
                     ce_r  <= ChipEnable;
                     we_r  <= is_store(op_in) ? WriteEnable : WriteDisable;
                     state <= ST_ACCESS;
                  end
               end
            end
            ST_ACCESS: begin
               if (count == 4'd0) begin
                  // The RAM word is valid in the last enabled cycle.
                  if (!is_store(op_q)) rdata_q <= rdata_ext;
                  ce_r   <= ChipDisable;
                  we_r   <= WriteDisable;
                  done_r <= 1'b1;
                  state  <= ST_DONE;
               end else begin
                  count <= count - 4'd1;
               end
            end
            ST_DONE: begin
               done_r <= 1'b0;
               err_r  <= 1'b0;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign stall_o   = accept || (state == ST_ACCESS);
   assign done_o    = done_r;
   assign err_o     = err_r;
   assign badaddr_o = err_r ? addr_q : '0;
   assign rdata_o   = done_r ? DATA_W'(rdata_q) : '0;

   assign ram.ce    = ce_r;
   assign ram.we    = we_r;
   assign ram.sel   = ce_r ? sel : 4'b0000;
   assign ram.addr  = ce_r ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign ram.wdata = ce_r ? wdata_rep : 32'h0;

endmodule

// File: tb/tb_data_mem_master.sv
// tb/tb_data_mem_master.sv - self-checking bench for data_mem_master
module tb_data_mem_master;
   import data_mem_master_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req_s   [2];
   logic [3:0]  op_s    [2];
   logic [31:0] addr_s  [2];
   logic [31:0] wdata_s [2];
   logic        flush_s [2];
   logic        stall_s [2];
   logic        done_s  [2];
   logic        err_s   [2];
   logic [31:0] bad_s   [2];
   logic [31:0] rdata_s [2];
   logic        ce_s    [2];
   logic        we_s    [2];
   logic [3:0]  sel_s   [2];
   logic [31:0] raddr_s [2];
   logic [31:0] rdat_s  [2];

   logic [31:0] ram_mem [2][256];
   logic [7:0]  ref_mem [2][1024];

   int n_checks = 0;
   int n_fail   = 0;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      data_mem_master_if #(.ADDR_W(32)) bus ();
      data_mem_master #(.LATENCY(g == 0 ? 1 : 3), .ADDR_W(32), .DATA_W(32)) dut (
         .clk       (clk),
         .rst       (rst),
         .req_i     (req_s[g]),
         .op_i      (op_s[g]),
         .addr_i    (addr_s[g]),
         .wdata_i   (wdata_s[g]),
         .flush_i   (flush_s[g]),
         .stall_o   (stall_s[g]),
         .done_o    (done_s[g]),
         .err_o     (err_s[g]),
         .badaddr_o (bad_s[g]),
         .rdata_o   (rdata_s[g]),
         .ram       (bus)
      );
      assign bus.rdata  = ram_mem[g][bus.addr[9:2]];
      assign ce_s[g]    = bus.ce;
      assign we_s[g]    = bus.we;
      assign sel_s[g]   = bus.sel;
      assign raddr_s[g] = bus.addr;
      assign rdat_s[g]  = bus.wdata;
   end

   // RAM: lane-masked write on the clock edge, combinational read.
   always @(posedge clk) begin
      for (int g = 0; g < 2; g++)
         if (ce_s[g] && we_s[g])
            for (int l = 0; l < 4; l++)
               if (sel_s[g][l]) ram_mem[g][raddr_s[g][9:2]][8*l +: 8] = rdat_s[g][8*l +: 8];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: byte-addressed memory, byte at offset 0 is most significant.
   function automatic int op_size(input logic [3:0] o);
      case (o)
         MEM_LH, MEM_LHU, MEM_SH: return 2;
         MEM_LW, MEM_SW:          return 4;
         default:                 return 1;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input int g, input logic [3:0] o, input logic [31:0] a);
      int i;
      logic [31:0] w;
      i = int'(a & 32'h3FF);
      case (o)
         MEM_LB:  w = 32'(signed'(ref_mem[g][i]));
         MEM_LBU: w = {24'h0, ref_mem[g][i]};
         MEM_LH:  w = 32'(signed'({ref_mem[g][i], ref_mem[g][i+1]}));
         MEM_LHU: w = {16'h0, ref_mem[g][i], ref_mem[g][i+1]};
         MEM_LW:  w = {ref_mem[g][i], ref_mem[g][i+1], ref_mem[g][i+2], ref_mem[g][i+3]};
         default: w = 32'h0;
      endcase
      return w;
   endfunction

   task automatic model_store(input int g, input logic [3:0] o, input logic [31:0] a, input logic [31:0] d);
      int i, sz;
      i  = int'(a & 32'h3FF);
      sz = op_size(o);
      for (int k = 0; k < sz; k++) ref_mem[g][i+k] = d[8*(sz-1-k) +: 8];
   endtask

   task automatic do_op(input int g, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] d, input bit flush_mid, output logic [31:0] rd);
      int lat, sz, ce_cnt;
      bit mis, st, got_done;
      logic [31:0] exp_rd, exp_data;
      logic [3:0]  exp_sel;
      rd  = 32'h0;
      lat = (g == 0) ? 1 : 3;
      sz  = op_size(o);
      st  = (o == MEM_SB) || (o == MEM_SH) || (o == MEM_SW);
      mis = (int'(a[1:0]) % sz) != 0;
      exp_rd = (st || mis) ? 32'h0 : model_load(g, o, a);
      exp_sel = 4'b0000;
      for (int k = 0; k < sz; k++) exp_sel[3 - (int'(a[1:0]) + k) % 4] = 1'b1;
      exp_data = (sz == 1) ? {4{d[7:0]}} : (sz == 2) ? {2{d[15:0]}} : d;

      @(negedge clk);
      req_s[g] = 1'b1; op_s[g] = o; addr_s[g] = a; wdata_s[g] = d;
      #1 check("stall_accept", 32'(stall_s[g]), 32'd1);
      ce_cnt = 0;
      got_done = 0;
      for (int cyc = 1; cyc <= 20 && !got_done; cyc++) begin
         @(negedge clk);
         if (flush_mid && cyc == 1) flush_s[g] = 1'b1;
         #1;
         if (done_s[g]) begin
            got_done = 1;
            check("done_cycle", 32'(cyc), mis ? 32'd1 : 32'(lat + 1));
            check("err", 32'(err_s[g]), 32'(mis));
            check("badaddr", bad_s[g], mis ? a : 32'h0);
            check("rdata", rdata_s[g], exp_rd);
            check("stall_done", 32'(stall_s[g]), 32'd0);
            check("ce_done", 32'(ce_s[g]), 32'd0);
            rd = rdata_s[g];
         end else begin
            check("stall_busy", 32'(stall_s[g]), 32'd1);
            if (ce_s[g]) begin
               ce_cnt++;
               check("ram_we", 32'(we_s[g]), 32'(st));
               check("ram_sel", 32'(sel_s[g]), 32'(exp_sel));
               check("ram_addr", raddr_s[g], a & 32'hFFFF_FFFC);
               if (st) check("ram_data", rdat_s[g], exp_data);
            end
         end
      end
      if (!got_done) check("done_timeout", 32'd0, 32'd1);
      check("ce_cycles", 32'(ce_cnt), mis ? 32'd0 : 32'(lat));
      req_s[g] = 1'b0;
      flush_s[g] = 1'b0;
      if (st && !mis) model_store(g, o, a, d);
   endtask

   initial begin
      logic [31:0] rd, w, a;
      logic [3:0]  o;
      int g;

      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         req_s[i] = 1'b0; op_s[i] = 4'd0; addr_s[i] = 32'h0; wdata_s[i] = 32'h0; flush_s[i] = 1'b0;
         for (int wi = 0; wi < 256; wi++) begin
            w = $urandom;
            ram_mem[i][wi] = w;
            for (int k = 0; k < 4; k++) ref_mem[i][wi*4 + k] = w[8*(3-k) +: 8];
         end
      end
      repeat (3) @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         check("rst_stall", 32'(stall_s[i]), 32'd0);
         check("rst_done", 32'(done_s[i]), 32'd0);
         check("rst_err", 32'(err_s[i]), 32'd0);
         check("rst_badaddr", bad_s[i], 32'h0);
         check("rst_rdata", rdata_s[i], 32'h0);
         check("rst_ram_ce", 32'(ce_s[i]), 32'd0);
         check("rst_ram_we", 32'(we_s[i]), 32'd0);
         check("rst_ram_sel", 32'(sel_s[i]), 32'd0);
         check("rst_ram_addr", raddr_s[i], 32'h0);
         check("rst_ram_data", rdat_s[i], 32'h0);
      end
      rst = 1'b0;

      // Store then load back, LATENCY=1.
      do_op(0, MEM_SW, 32'h10, 32'hDEADBEEF, 0, rd);
      do_op(0, MEM_LW, 32'h10, 32'h0, 0, rd);
      check("lw_back", rd, 32'hDEADBEEF);

      // Extraction and extension.
      do_op(0, MEM_SW, 32'h20, 32'h8091A2B3, 0, rd);
      do_op(0, MEM_LB, 32'h21, 32'h0, 0, rd);  check("lb_21", rd, 32'hFFFFFF91);
      do_op(0, MEM_LBU, 32'h21, 32'h0, 0, rd); check("lbu_21", rd, 32'h00000091);
      do_op(0, MEM_LH, 32'h22, 32'h0, 0, rd);  check("lh_22", rd, 32'hFFFFA2B3);
      do_op(0, MEM_LHU, 32'h20, 32'h0, 0, rd); check("lhu_20", rd, 32'h00008091);

      // Sub-word stores.
      do_op(0, MEM_SB, 32'h33, 32'h000000AA, 0, rd);
      do_op(0, MEM_SH, 32'h32, 32'h00001234, 0, rd);
      do_op(0, MEM_LW, 32'h30, 32'h0, 0, rd);

      // Misaligned word.
      do_op(0, MEM_LW, 32'h41, 32'h0, 0, rd);

      // LATENCY=3 load and store.
      do_op(1, MEM_SW, 32'h80, 32'hCAFEF00D, 0, rd);
      do_op(1, MEM_LW, 32'h80, 32'h0, 0, rd);
      check("lat3_lw", rd, 32'hCAFEF00D);

      // Reset in the middle of an access.
      @(negedge clk);
      req_s[1] = 1'b1; op_s[1] = MEM_LW; addr_s[1] = 32'h0;
      @(negedge clk);
      #1 check("rst_mid_ce_t1", 32'(ce_s[1]), 32'd1);
      @(negedge clk);
      rst = 1'b1; req_s[1] = 1'b0;
      #1 check("rst_mid_ce_t2", 32'(ce_s[1]), 32'd1);
      @(negedge clk);
      #1;
      check("rst_mid_ce_t3", 32'(ce_s[1]), 32'd0);
      check("rst_mid_stall_t3", 32'(stall_s[1]), 32'd0);
      check("rst_mid_done_t3", 32'(done_s[1]), 32'd0);
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         #1 check("rst_mid_no_done", 32'(done_s[1]), 32'd0);
      end

      // Flush in IDLE blocks acceptance.
      @(negedge clk);
      req_s[0] = 1'b1; op_s[0] = MEM_SW; addr_s[0] = 32'h50; wdata_s[0] = 32'h11223344; flush_s[0] = 1'b1;
      repeat (3) begin
         #1;
         check("flush_stall", 32'(stall_s[0]), 32'd0);
         check("flush_ce", 32'(ce_s[0]), 32'd0);
         @(negedge clk);
      end
      req_s[0] = 1'b0; flush_s[0] = 1'b0;
      do_op(0, MEM_LW, 32'h50, 32'h0, 0, rd);

      // Flush during ACCESS does not abort.
      do_op(1, MEM_SW, 32'h60, 32'h55667788, 1, rd);
      do_op(1, MEM_LW, 32'h60, 32'h0, 0, rd);
      check("flush_mid_store", rd, 32'h55667788);

      // Random ops on both latencies.
      for (int i = 0; i < 200; i++) begin
         g = i % 2;
         o = 4'($urandom_range(1, 8));
         a = 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 3) != 0) a = a & ~32'(op_size(o) - 1);
         do_op(g, o, a, $urandom, 0, rd);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
